// File: rtl/pipeline_hazard_unit.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Decode-stage hazard and issue controller. Keeps a small scoreboard of the
// destination registers held by instructions in stages 1..STAGES (1 = execute,
// STAGES = writeback). From that scoreboard it decides whether the decode
// instruction may issue, selects per-operand forwarding sources, inserts
// issue bubbles after a taken jump (flush), and runs the ebreak
// drain/halt sequence. The datapath pipeline registers live elsewhere.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   valid_in     in   decode holds a valid instruction
//   rs1, rs2     in   source register numbers
//   uses_rs1/2   in   operand is actually read
//   rd           in   destination register number
//   reg_we       in   instruction writes rd
//   load_memory  in   instruction is a load
//   ebreak       in   instruction is ebreak
//   flush        in   taken jump resolved in stage 1 this cycle
//   resume       in   leave HALTED
//   issue        out  decode instruction enters stage 1 at this edge
//   stall        out  decode/fetch must hold
//   fwd_rs1_sel  out  0 = register file, k = forward from stage k
//   fwd_rs2_sel  out  same for rs2
//   pipe_empty   out  no valid entry in stages 1..STAGES
//   halted       out  controller is in HALTED
// ----------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int STAGES        = 3,
    parameter int FORWARD       = 1,
    parameter int LOAD_STAGE    = 2,
    parameter int FLUSH_BUBBLES = 1,
    parameter int SEL_W         = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             uses_rs1,
    input  logic             uses_rs2,
    input  logic [4:0]       rd,
    input  logic             reg_we,
    input  logic             load_memory,
    input  logic             ebreak,
    input  logic             flush,
    input  logic             resume,
    output logic             issue,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_rs1_sel,
    output logic [SEL_W-1:0] fwd_rs2_sel,
    output logic             pipe_empty,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      bc_q, bc_d;

    // Scoreboard: entry k describes the instruction currently in stage k.
    logic [STAGES:1] valid_q;
    logic [STAGES:1] we_q;
    logic [STAGES:1] load_q;
    logic [4:0]      rd_q [1:STAGES];

    // Youngest-match search results per operand (0 = no match).
    int              k1, k2;
    logic            load1, load2;
    logic            hazard;

    // ------------------------------------------------------------------------
    // Operand match search. Scanning from the oldest stage down to stage 1
    // lets the last hit seen be the youngest one, which is the value the
    // operand must observe. x0 never matches.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned and no latch is inferred.
        k1    = 0;
        k2    = 0;
        load1 = 1'b0;
        load2 = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (valid_q[k] && we_q[k]) begin
                if (uses_rs1 && (rs1 != 5'd0) && (rd_q[k] == rs1)) begin
                    k1    = k;
                    load1 = load_q[k];
                end
                if (uses_rs2 && (rs2 != 5'd0) && (rd_q[k] == rs2)) begin
                    k2    = k;
                    load2 = load_q[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hazard and forwarding selects. With forwarding, only a load whose data
    // is not yet available (stage below LOAD_STAGE) blocks issue. Without
    // forwarding, any pending writer blocks until it has left writeback.
    // ------------------------------------------------------------------------
    always_comb begin
        hazard      = 1'b0;
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        if (FORWARD != 0) begin
            fwd_rs1_sel = SEL_W'(k1);
            fwd_rs2_sel = SEL_W'(k2);
            hazard      = ((k1 != 0) && load1 && (k1 < LOAD_STAGE)) ||
                          ((k2 != 0) && load2 && (k2 < LOAD_STAGE));
        end else begin
            hazard      = (k1 != 0) || (k2 != 0);
        end
    end

    assign issue      = valid_in && (state_q == ST_RUN) && (bc_q == 4'd0) &&
                        !flush && !hazard;
    // A flushed decode instruction is discarded, so it is never held.
    assign stall      = valid_in && !issue && !flush;
    assign pipe_empty = ~|valid_q;
    assign halted     = (state_q == ST_HALTED);

    // ------------------------------------------------------------------------
    // Next state. While draining nothing enters stage 1, so after this edge
    // the pipe is empty exactly when stages 1..STAGES-1 are empty now. Going
    // to HALTED on that condition makes halted rise in the first cycle the
    // pipe is observed empty, i.e. the cycle after the ebreak retires.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (issue && ebreak)          state_d = ST_DRAIN;
            ST_DRAIN:  if (~|valid_q[STAGES-1:1])    state_d = ST_HALTED;
            ST_HALTED: if (resume)                   state_d = ST_RUN;
            default:                                 state_d = ST_RUN;
        endcase
    end

    always_comb begin
        if (flush) begin
            bc_d = 4'(FLUSH_BUBBLES);
        end else if (bc_q != 4'd0) begin
            bc_d = bc_q - 4'd1;
        end else begin
            bc_d = bc_q;
        end
    end

    // ------------------------------------------------------------------------
    // Control state and scoreboard valid bits.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= ST_RUN;
            bc_q    <= 4'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            valid_q <= {valid_q[STAGES-1:1], issue};
        end
    end

    // NOTE: the scoreboard payload is deliberately not reset; it is only
    // ever looked at through its valid bit, which is reset above.
    always_ff @(posedge clk) begin
        rd_q[1] <= rd;
        for (int k = 2; k <= STAGES; k++) begin
            rd_q[k] <= rd_q[k-1];
        end
        we_q   <= {we_q[STAGES-1:1], reg_we};
        load_q <= {load_q[STAGES-1:1], load_memory};
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid_in, uses_rs1, uses_rs2, reg_we, load_memory;
    logic       ebreak, flush, resume;
    logic [4:0] rs1, rs2, rd;

    int checks = 0;
    int errors = 0;

    // Default instance: STAGES=3, FORWARD=1, LOAD_STAGE=2, FLUSH_BUBBLES=1
    logic       d_issue, d_stall, d_empty, d_halted;
    logic [1:0] d_sel1, d_sel2;
    // No forwarding network
    logic       n_issue, n_stall, n_empty, n_halted;
    logic [1:0] n_sel1, n_sel2;
    // Two flush bubbles
    logic       f_issue, f_stall, f_empty, f_halted;
    logic [1:0] f_sel1, f_sel2;

    pipeline_hazard_unit u_def (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rs1(rs1), .rs2(rs2),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rd(rd), .reg_we(reg_we),
        .load_memory(load_memory), .ebreak(ebreak), .flush(flush), .resume(resume),
        .issue(d_issue), .stall(d_stall), .fwd_rs1_sel(d_sel1), .fwd_rs2_sel(d_sel2),
        .pipe_empty(d_empty), .halted(d_halted)
    );

    pipeline_hazard_unit #(.FORWARD(0)) u_nf (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rs1(rs1), .rs2(rs2),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rd(rd), .reg_we(reg_we),
        .load_memory(load_memory), .ebreak(ebreak), .flush(flush), .resume(resume),
        .issue(n_issue), .stall(n_stall), .fwd_rs1_sel(n_sel1), .fwd_rs2_sel(n_sel2),
        .pipe_empty(n_empty), .halted(n_halted)
    );

    pipeline_hazard_unit #(.FLUSH_BUBBLES(2)) u_fb (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rs1(rs1), .rs2(rs2),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rd(rd), .reg_we(reg_we),
        .load_memory(load_memory), .ebreak(ebreak), .flush(flush), .resume(resume),
        .issue(f_issue), .stall(f_stall), .fwd_rs1_sel(f_sel1), .fwd_rs2_sel(f_sel2),
        .pipe_empty(f_empty), .halted(f_halted)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] r1, input logic u1,
                             input logic [4:0] r2, input logic u2, input logic [4:0] d,
                             input logic we, input logic ld, input logic eb);
        valid_in = v; rs1 = r1; uses_rs1 = u1; rs2 = r2; uses_rs2 = u2;
        rd = d; reg_we = we; load_memory = ld; ebreak = eb;
    endtask

    task automatic apply_reset();
        rst = 1'b1; flush = 1'b0; resume = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; resume = 1'b0;
        set_instr(1, 0, 0, 0, 0, 5'd1, 1, 0, 0);
        tick();
        // Second reset cycle, decode idle: the pure reset-state outputs.
        valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_empty, d_halted} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0010", {d_issue, d_stall, d_empty, d_halted});
        end
        checks++;
        if ({d_sel1, d_sel2} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sel: got %b expected 0000", {d_sel1, d_sel2});
        end
        valid_in = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_empty, d_halted} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_first_issue: got %b expected 1010", {d_issue, d_stall, d_empty, d_halted});
        end
        checks++;
        if ({n_empty, f_empty, n_halted, f_halted} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_other_instances: got %b expected 1100", {n_empty, f_empty, n_halted, f_halted});
        end
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_instr(1, 0, 0, 0, 0, 5'd5, 1, 1, 0);           // lw x5
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall} !== 2'b10) begin
            errors++;
            $display("FAIL lu_load_issue: got %b expected 10", {d_issue, d_stall});
        end
        tick();
        set_instr(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);     // add x6,x5,x5
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall} !== 2'b01) begin
            errors++;
            $display("FAIL lu_stall: got %b expected 01", {d_issue, d_stall});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall} !== 2'b10) begin
            errors++;
            $display("FAIL lu_issue_after_stall: got %b expected 10", {d_issue, d_stall});
        end
        checks++;
        if ({d_sel1, d_sel2} !== {2'd2, 2'd2}) begin
            errors++;
            $display("FAIL lu_fwd_sel: got %0d/%0d expected 2/2", d_sel1, d_sel2);
        end
        tick();
        set_instr(1, 5'd0, 1, 0, 0, 5'd5, 1, 0, 0);        // addi x5,x0,..
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall} !== 2'b10) begin
            errors++;
            $display("FAIL alu_writer_issue: got %b expected 10", {d_issue, d_stall});
        end
        tick();
        set_instr(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);     // add x6,x5,x5
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_sel1, d_sel2} !== {2'b10, 2'd1, 2'd1}) begin
            errors++;
            $display("FAIL alu_fwd: got issue/stall=%b sel=%0d/%0d expected 10 sel=1/1",
                     {d_issue, d_stall}, d_sel1, d_sel2);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_priority();
        apply_reset();
        set_instr(1, 0, 0, 0, 0, 5'd7, 1, 0, 0); tick();  // writer x7 -> stage 3
        set_instr(1, 0, 0, 0, 0, 5'd8, 1, 0, 0); tick();  // writer x8 -> stage 2
        set_instr(1, 0, 0, 0, 0, 5'd7, 1, 0, 0); tick();  // writer x7 -> stage 1
        set_instr(1, 5'd7, 1, 5'd8, 1, 5'd10, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_sel1, d_sel2} !== {2'b10, 2'd1, 2'd2}) begin
            errors++;
            $display("FAIL youngest_wins: got issue/stall=%b sel=%0d/%0d expected 10 sel=1/2",
                     {d_issue, d_stall}, d_sel1, d_sel2);
        end
        tick();
        set_instr(1, 0, 0, 0, 0, 5'd0, 1, 0, 0); tick();  // writer of x0
        set_instr(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0);   // reads x0,x0
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_sel1, d_sel2} !== {2'b10, 2'd0, 2'd0}) begin
            errors++;
            $display("FAIL x0_no_match: got issue/stall=%b sel=%0d/%0d expected 10 sel=0/0",
                     {d_issue, d_stall}, d_sel1, d_sel2);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_no_forward();
        apply_reset();
        set_instr(1, 0, 0, 0, 0, 5'd3, 1, 0, 0);           // writer x3
        @(negedge clk);
        checks++;
        if ({n_issue, n_stall} !== 2'b10) begin
            errors++;
            $display("FAIL nf_writer_issue: got %b expected 10", {n_issue, n_stall});
        end
        tick();
        set_instr(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0);     // reader x3
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({n_issue, n_stall, n_sel1, n_sel2} !== {2'b01, 2'd0, 2'd0}) begin
                errors++;
                $display("FAIL nf_stall_cycle%0d: got issue/stall=%b sel=%0d/%0d expected 01 sel=0/0",
                         c, {n_issue, n_stall}, n_sel1, n_sel2);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({n_issue, n_stall, n_sel1, n_sel2} !== {2'b10, 2'd0, 2'd0}) begin
            errors++;
            $display("FAIL nf_issue_after_wb: got issue/stall=%b sel=%0d/%0d expected 10 sel=0/0",
                     {n_issue, n_stall}, n_sel1, n_sel2);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        set_instr(1, 0, 0, 0, 0, 5'd5, 1, 1, 0);           // lw x5
        tick();
        set_instr(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);     // dependent reader
        flush = 1'b1;                                      // cycle t
        @(negedge clk);
        checks++;
        if ({f_issue, f_stall} !== 2'b00) begin
            errors++;
            $display("FAIL flush_beats_hazard: got %b expected 00", {f_issue, f_stall});
        end
        tick();
        flush = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if ({f_issue, f_stall} !== 2'b01) begin
                errors++;
                $display("FAIL flush_bubble%0d: got %b expected 01", c, {f_issue, f_stall});
            end
            tick();
        end
        @(negedge clk);                                    // t+3
        checks++;
        if ({f_issue, f_stall, f_empty, f_sel1} !== {3'b101, 2'd0}) begin
            errors++;
            $display("FAIL flush_reopen: got issue/stall/empty=%b sel=%0d expected 101 sel=0",
                     {f_issue, f_stall, f_empty}, f_sel1);
        end
        tick();
        // Reset while bubbles are still pending clears the bubble counter.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({f_issue, f_stall} !== 2'b01) begin
            errors++;
            $display("FAIL flush_pending: got %b expected 01", {f_issue, f_stall});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({f_issue, f_stall, f_empty} !== 3'b101) begin
            errors++;
            $display("FAIL rst_clears_bubbles: got %b expected 101", {f_issue, f_stall, f_empty});
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_ebreak();
        apply_reset();
        set_instr(1, 0, 0, 0, 0, 5'd0, 0, 0, 1);           // ebreak at t
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_halted} !== 3'b100) begin
            errors++;
            $display("FAIL eb_issue: got %b expected 100", {d_issue, d_stall, d_halted});
        end
        tick();
        set_instr(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);           // independent follower
        for (int c = 1; c <= 3; c++) begin
            resume = (c == 2);                             // ignored outside HALTED
            @(negedge clk);
            checks++;
            if ({d_issue, d_stall, d_empty, d_halted} !== 4'b0100) begin
                errors++;
                $display("FAIL eb_drain_t%0d: got %b expected 0100", c, {d_issue, d_stall, d_empty, d_halted});
            end
            tick();
        end
        resume = 1'b1;                                     // t+4
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_empty, d_halted} !== 4'b0111) begin
            errors++;
            $display("FAIL eb_halted: got %b expected 0111", {d_issue, d_stall, d_empty, d_halted});
        end
        tick();
        resume = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_empty, d_halted} !== 4'b1010) begin
            errors++;
            $display("FAIL eb_resume: got %b expected 1010", {d_issue, d_stall, d_empty, d_halted});
        end
        tick();
        // Second ebreak, then reset in the middle of the drain.
        set_instr(1, 0, 0, 0, 0, 5'd0, 0, 0, 1);
        @(negedge clk);
        checks++;
        if (d_issue !== 1'b1) begin
            errors++;
            $display("FAIL eb2_issue: got %b expected 1", d_issue);
        end
        tick();
        set_instr(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_empty, d_halted} !== 4'b0100) begin
            errors++;
            $display("FAIL eb2_drain: got %b expected 0100", {d_issue, d_stall, d_empty, d_halted});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_issue, d_stall, d_empty, d_halted} !== 4'b1010) begin
            errors++;
            $display("FAIL rst_mid_drain: got %b expected 1010", {d_issue, d_stall, d_empty, d_halted});
        end
        tick();
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_priority();
        test_no_forward();
        test_flush();
        test_ebreak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
